// File: rtl/ct_f_spsram_fifo_ctrl_pkg.sv
// Shared definitions for the single-port-SRAM FIFO controller: geometry defaults,
// output-buffer depth and the per-cycle SRAM operation encoding.
package ct_f_spsram_fifo_ctrl_pkg;

  localparam int DATA_WIDTH = 44;
  localparam int ADDR_WIDTH = 9;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int OB_DEPTH   = 2;
  localparam int OB_CNT_W   = $clog2(OB_DEPTH + 1);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } sram_op_e;

endpackage

// File: rtl/ct_f_spsram_fifo_ctrl_if.sv
// Push/pop handshake, status and SRAM pin bundle of the FIFO controller.
// slave = controller view, master = environment (producer, consumer, SRAM) view.
interface ct_f_spsram_fifo_ctrl_if;
  import ct_f_spsram_fifo_ctrl_pkg::*;

  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_rdy;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_rdy;
  logic [CNT_WIDTH-1:0]  fifo_cnt;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  wr_vld, wr_data, rd_rdy, sram_q,
    output wr_rdy, rd_vld, rd_data, fifo_cnt, fifo_empty, fifo_full,
           sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );

  modport master (
    output wr_vld, wr_data, rd_rdy, sram_q,
    input  wr_rdy, rd_vld, rd_data, fifo_cnt, fifo_empty, fifo_full,
           sram_cen, sram_gwen, sram_wen, sram_a, sram_d
  );

endinterface

// File: rtl/ct_f_spsram_fifo_ctrl_ob.sv
// Two-entry output buffer that absorbs SRAM read data; head entry drives the consumer
// directly from registers.
module ct_f_spsram_fifo_ob
  import ct_f_spsram_fifo_ctrl_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_b_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  vld_o,
  output logic [OB_CNT_W-1:0]   cnt_o
);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [OB_CNT_W-1:0]   cnt_q, cnt_d;

  // The producer side never pushes into a full buffer unless it pops the same cycle.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_i) begin
          ent0_d = din_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push_i && pop_i) begin
          ent0_d = din_i;
        end else if (push_i) begin
          ent1_d = din_i;
          cnt_d  = 2'd2;
        end else if (pop_i) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        if (pop_i) begin
          ent0_d = ent1_q;
          if (push_i) ent1_d = din_i;
          else        cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = ent0_q;
  assign vld_o  = (cnt_q != '0);
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/ct_f_spsram_fifo_ctrl.sv
// Valid/ready FIFO on one single-port SRAM, one access per cycle, 2-entry output buffer.
// Optional SPSRAM_FIFO_BYPASS_EN lets pushes skip the SRAM when it and the read path are empty.
module ct_f_spsram_fifo_ctrl
  import ct_f_spsram_fifo_ctrl_pkg::*;
(
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  ct_f_spsram_fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] CntFull = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d, sram_a_q, sram_a_d;
  logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_turn_q, wr_turn_d;
  logic [OB_CNT_W-1:0]   ob_cnt;
  logic [2:0]            ob_after;
  logic                  ob_vld, ob_push, pop;
  logic [DATA_WIDTH-1:0] ob_din, ob_head;
  logic                  full, rd_elig, rd_prio, rd_sel, wr_rdy, wr_sel, byp_sel;
  sram_op_e              op;

  assign pop      = ob_vld & bus.rd_rdy;
  assign ob_after = {1'b0, ob_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign full     = (sram_cnt_q == CntFull);
  assign rd_elig  = cpurst_b & (sram_cnt_q != '0) & (ob_after < 3'd2);
  assign rd_prio  = (ob_cnt == '0) & ~inflight_q;
  // wr_turn_q remembers a push that lost to a read, so the next slot goes to the push;
  // it is registered so that wr_rdy never depends combinationally on wr_vld.
  assign rd_sel   = rd_elig & (rd_prio | ~wr_turn_q);
  assign wr_rdy   = cpurst_b & ~full & ~rd_sel;

`ifdef SPSRAM_FIFO_BYPASS_EN
  assign byp_sel = bus.wr_vld & wr_rdy & (sram_cnt_q == '0) & ~inflight_q
                 & ((ob_cnt - {1'b0, pop}) < 2'd2);
`else
  assign byp_sel = 1'b0;
`endif

  assign wr_sel = bus.wr_vld & wr_rdy & ~byp_sel;

  always_comb begin
    op = OP_IDLE;
    if (rd_sel)      op = OP_RD;
    else if (wr_sel) op = OP_WR;
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    sram_cnt_d = sram_cnt_q;
    sram_a_d   = sram_a_q;
    inflight_d = 1'b0;
    wr_turn_d  = 1'b0;
    case (op)
      OP_WR: begin
        wptr_d     = wptr_q + ADDR_WIDTH'(1);
        sram_cnt_d = sram_cnt_q + (ADDR_WIDTH + 1)'(1);
        sram_a_d   = wptr_q;
      end
      OP_RD: begin
        rptr_d     = rptr_q + ADDR_WIDTH'(1);
        sram_cnt_d = sram_cnt_q - (ADDR_WIDTH + 1)'(1);
        sram_a_d   = rptr_q;
        inflight_d = 1'b1;
        wr_turn_d  = bus.wr_vld;
      end
      default: ;
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      sram_a_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      wr_turn_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      sram_a_q   <= sram_a_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      wr_turn_q  <= wr_turn_d;
    end
  end

  // Bypass and read return are mutually exclusive because bypass requires no read in flight.
  assign ob_push = inflight_q | byp_sel;
  assign ob_din  = byp_sel ? bus.wr_data : bus.sram_q;

  ct_f_spsram_fifo_ob u_ob (
    .clk_i   (forever_cpuclk),
    .rst_b_i (cpurst_b),
    .push_i  (ob_push),
    .din_i   (ob_din),
    .pop_i   (pop),
    .head_o  (ob_head),
    .vld_o   (ob_vld),
    .cnt_o   (ob_cnt)
  );

  assign bus.wr_rdy     = wr_rdy;
  assign bus.rd_vld     = ob_vld;
  assign bus.rd_data    = ob_head;
  assign bus.fifo_cnt   = CNT_WIDTH'(sram_cnt_q) + CNT_WIDTH'(inflight_q) + CNT_WIDTH'(ob_cnt);
  assign bus.fifo_empty = (bus.fifo_cnt == '0);
  assign bus.fifo_full  = full;
  assign bus.sram_cen   = (op == OP_IDLE);
  assign bus.sram_gwen  = (op != OP_WR);
  assign bus.sram_wen   = {DATA_WIDTH{op != OP_WR}};
  assign bus.sram_a     = sram_a_d;
  assign bus.sram_d     = bus.wr_data;

endmodule

// File: tb/tb_ct_f_spsram_fifo_ctrl.sv
// Directed bench for ct_f_spsram_fifo_ctrl with a behavioural 512x44 single-port SRAM.
// Expected latency follows SPSRAM_FIFO_BYPASS_EN when it is defined.
module tb_ct_f_spsram_fifo_ctrl;
  import ct_f_spsram_fifo_ctrl_pkg::*;

`ifdef SPSRAM_FIFO_BYPASS_EN
  localparam int FirstLat = 1;
`else
  localparam int FirstLat = 3;
`endif

  logic forever_cpuclk = 1'b0;
  logic cpurst_b;
  int   vectors = 0;
  int   miscompares = 0;

  ct_f_spsram_fifo_ctrl_if bus ();

  ct_f_spsram_fifo_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .bus            (bus)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  // Behavioural SRAM: masked write, registered read data.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] memQ = '0;
  always @(posedge forever_cpuclk) begin
    if (!bus.sram_cen) begin
      if (!bus.sram_gwen) mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
      else                memQ <= mem[bus.sram_a];
    end
  end
  assign bus.sram_q = memQ;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_WIDTH-1:0] d, input logic r);
    bus.wr_vld  = v;
    bus.wr_data = d;
    bus.rd_rdy  = r;
    #1;
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] model [$];
    logic [DATA_WIDTH-1:0] allOnes;
    logic [DATA_WIDTH-1:0] t1Data;
    int lat, acc, seq, errs, cntErrs, gaps, pops, rds, wrs, sameOp, prevOp, curOp, quiet;
    logic wv, rr;

    allOnes = '1;
    t1Data  = 44'h0AB_CDEF_0123;
    seq     = 0;

    // Reset: state cleared, wr_rdy held low even with a push offered.
    cpurst_b = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b1, 44'h1, 1'b1);
    checkOutput("rst_rd_vld", bus.rd_vld, 0);
    checkOutput("rst_fifo_cnt", bus.fifo_cnt, 0);
    checkOutput("rst_empty", bus.fifo_empty, 1);
    checkOutput("rst_full", bus.fifo_full, 0);
    checkOutput("rst_wr_rdy", bus.wr_rdy, 0);
    checkOutput("rst_cen", bus.sram_cen, 1);
    checkOutput("rst_gwen", bus.sram_gwen, 1);
    checkOutput("rst_wen", bus.sram_wen, 64'(allOnes));
    tick();

    // Single push with the consumer ready.
    cpurst_b = 1'b1;
    applyStimulus(1'b1, t1Data, 1'b1);
    checkOutput("t1_wr_rdy", bus.wr_rdy, 1);
`ifdef SPSRAM_FIFO_BYPASS_EN
    checkOutput("t1_cen_bypass", bus.sram_cen, 1);
`else
    checkOutput("t1_cen_write", bus.sram_cen, 0);
    checkOutput("t1_gwen_write", bus.sram_gwen, 0);
    checkOutput("t1_wen_write", bus.sram_wen, 0);
    checkOutput("t1_addr", bus.sram_a, 0);
`endif
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    lat = 1;
    while (!bus.rd_vld && lat < 10) begin
      tick();
      applyStimulus(1'b0, '0, 1'b1);
      lat++;
    end
    checkOutput("t1_latency", 64'(lat), 64'(FirstLat));
    checkOutput("t1_data", bus.rd_data, 64'(t1Data));
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t1_empty_after_pop", bus.fifo_empty, 1);
    checkOutput("t1_cnt_after_pop", bus.fifo_cnt, 0);

    // Fill to DEPTH+2 with the consumer stalled.
    acc = 0;
    for (int c = 0; c < 2000 && acc < DEPTH + 2; c++) begin
      applyStimulus(1'b1, DATA_WIDTH'(acc), 1'b0);
      if (bus.wr_rdy) acc++;
      tick();
    end
    checkOutput("t2_accepted", 64'(acc), 64'(DEPTH + 2));
    applyStimulus(1'b1, 44'hDEAD, 1'b0);
    checkOutput("t2_cnt_full", bus.fifo_cnt, 514);
    checkOutput("t2_full", bus.fifo_full, 1);
    checkOutput("t2_wr_rdy_full", bus.wr_rdy, 0);
    checkOutput("t2_head_vld", bus.rd_vld, 1);
    checkOutput("t2_head_data", bus.rd_data, 0);
    tick();
    applyStimulus(1'b1, 44'hDEAD, 1'b0);
    checkOutput("t2_cnt_hold", bus.fifo_cnt, 514);

    // Drain from full: one pop every cycle, data in order across pointer wrap.
    errs = 0;
    gaps = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (!bus.rd_vld) gaps++;
      else if (bus.rd_data !== DATA_WIDTH'(i)) errs++;
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t3_gap_cycles", 64'(gaps), 0);
    checkOutput("t3_order_errs", 64'(errs), 0);
    checkOutput("t3_empty", bus.fifo_empty, 1);
    checkOutput("t3_rd_vld", bus.rd_vld, 0);

    // Random traffic against a reference queue.
    errs = 0;
    cntErrs = 0;
    pops = 0;
    seq = 1000;
    for (int c = 0; c < 3000; c++) begin
      wv = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      applyStimulus(wv, DATA_WIDTH'(seq), rr);
      if (bus.rd_vld && rr) begin
        pops++;
        if (model.size() == 0) errs++;
        else if (bus.rd_data !== model.pop_front()) errs++;
      end
      if (wv && bus.wr_rdy) begin
        model.push_back(DATA_WIDTH'(seq));
        seq++;
      end
      tick();
      if (bus.fifo_cnt !== CNT_WIDTH'(model.size())) cntErrs++;
    end
    checkOutput("t4_order_errs", 64'(errs), 0);
    checkOutput("t4_cnt_errs", 64'(cntErrs), 0);
    checkOutput("t4_traffic", 64'(pops > 300), 1);

    // Steady push + pop around 100 entries.
    for (int c = 0; c < 1500 && !bus.fifo_empty; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tick();
    end
    model.delete();
    acc = 0;
    for (int c = 0; c < 1000 && acc < 100; c++) begin
      applyStimulus(1'b1, DATA_WIDTH'(seq), 1'b0);
      if (bus.wr_rdy) begin
        model.push_back(DATA_WIDTH'(seq));
        seq++;
        acc++;
      end
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t5_fill_cnt", bus.fifo_cnt, 100);
    errs = 0;
    cntErrs = 0;
    pops = 0;
    rds = 0;
    wrs = 0;
    sameOp = 0;
    prevOp = 0;
    for (int c = 0; c < 200; c++) begin
      applyStimulus(1'b1, DATA_WIDTH'(seq), 1'b1);
      curOp = bus.sram_cen ? 0 : (bus.sram_gwen ? 2 : 1);
      if (curOp == 1) wrs++;
      if (curOp == 2) rds++;
      if (curOp != 0) begin
        if (curOp == prevOp) sameOp++;
        prevOp = curOp;
      end
      if (bus.rd_vld) begin
        pops++;
        if (model.size() == 0) errs++;
        else if (bus.rd_data !== model.pop_front()) errs++;
      end
      if (bus.wr_rdy) begin
        model.push_back(DATA_WIDTH'(seq));
        seq++;
      end
      tick();
      if (bus.fifo_cnt < 98 || bus.fifo_cnt > 102) cntErrs++;
    end
    checkOutput("t5_order_errs", 64'(errs), 0);
    checkOutput("t5_cnt_range_errs", 64'(cntErrs), 0);
    checkOutput("t5_back_to_back_ops", 64'(sameOp), 0);
    checkOutput("t5_pops_progress", 64'(pops >= 80), 1);
    checkOutput("t5_reads_progress", 64'(rds >= 80), 1);
    checkOutput("t5_writes_progress", 64'(wrs >= 80), 1);

    // Reset with a read in flight and the buffer occupied.
    for (int c = 0; c < 1500 && !bus.fifo_empty; c++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tick();
    end
    acc = 0;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      applyStimulus(1'b1, 44'h0CC_0000_0000 + DATA_WIDTH'(acc), 1'b0);
      if (bus.wr_rdy) acc++;
      tick();
    end
    repeat (4) begin
      applyStimulus(1'b0, '0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t6_setup_cnt", bus.fifo_cnt, 3);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t6_setup_read", bus.sram_cen, 0);
    tick();
    cpurst_b = 1'b0;
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t6_rd_vld", bus.rd_vld, 0);
    checkOutput("t6_fifo_cnt", bus.fifo_cnt, 0);
    checkOutput("t6_cen", bus.sram_cen, 1);
    cpurst_b = 1'b1;
    quiet = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      applyStimulus(1'b0, '0, 1'b1);
      if (!bus.rd_vld && bus.fifo_cnt == 0) quiet++;
    end
    checkOutput("t6_no_stale_capture", 64'(quiet), 3);
    applyStimulus(1'b1, 44'h0AB_0000_0055, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    lat = 1;
    while (!bus.rd_vld && lat < 10) begin
      tick();
      applyStimulus(1'b0, '0, 1'b1);
      lat++;
    end
    checkOutput("t6_post_reset_latency", 64'(lat), 64'(FirstLat));
    checkOutput("t6_post_reset_data", bus.rd_data, 64'(44'h0AB_0000_0055));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
